// File: rtl/load_counter_arbiter.sv
// Two-requester arbiter and sequencer for a shared loadable up-counter.
// Optional LCA_ROUND_ROBIN_EN selects round-robin ties; default is fixed priority.
module load_counter_arbiter #(
  parameter int unsigned     WIDTH = 4,
  parameter logic [WIDTH-1:0] TERM = '1
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ack,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ack,
  input  logic             abort,
  input  logic [WIDTH-1:0] cnt_q,
  output logic             cnt_load,
  output logic [WIDTH-1:0] cnt_in,
  output logic             cnt_inc,
  output logic             cnt_clr,
  output logic [1:0]       grant,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic             done_abort
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_d;
  logic             owner;
  logic [WIDTH-1:0] data_r;
  logic             id_r;
  logic             abort_r;
  logic             take;
  logic             pick1;
  logic             enter_done;

`ifdef LCA_ROUND_ROBIN_EN
  logic last;

  // last=1 means requester 1 was served most recently, so 0 wins a tie
  assign pick1 = req1_valid & (~req0_valid | ~last);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      last <= 1'b1;
    end else if (take) begin
      last <= pick1;
    end
  end
`else
  assign pick1 = req1_valid & ~req0_valid;
`endif

  always_comb begin
    state_d  = state;
    take     = 1'b0;
    cnt_load = 1'b0;
    cnt_inc  = 1'b0;
    cnt_clr  = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (clear_n && (req0_valid || req1_valid)) begin
          take    = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_load = 1'b1;
        state_d  = abort ? DONE : RUN;
      end
      RUN: begin
        if (abort || (cnt_q == TERM)) begin
          state_d = DONE;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      DONE: begin
        cnt_clr = 1'b1;
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign enter_done = (state_d == DONE) && (state != DONE);

  always_ff @(posedge clk) begin
    if (!clear_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      data_r  <= '0;
      id_r    <= 1'b0;
      abort_r <= 1'b0;
    end else begin
      state <= state_d;
      if (take) begin
        owner  <= pick1;
        data_r <= pick1 ? req1_data : req0_data;
      end
      if (enter_done) begin
        id_r    <= owner;
        abort_r <= abort;
      end
    end
  end

  assign req0_ack   = take & ~pick1;
  assign req1_ack   = take & pick1;
  assign cnt_in     = data_r;
  assign busy       = (state != IDLE);
  assign grant      = ((state == LOAD) || (state == RUN)) ?
                      (owner ? 2'b10 : 2'b01) : 2'b00;
  assign done_id    = id_r;
  assign done_abort = done & abort_r;

endmodule
